// File: rtl/sprite_pkg.sv
// Shared parameters, state encoding and queue-entry type for the sprite blitter.
package sprite_pkg;
  localparam int SPRITE_W      = 32;
  localparam int SPRITE_H      = 32;
  localparam int SPRITE_NUM    = 16;
  localparam int FB_W          = 320;
  localparam int FB_H          = 240;
  localparam int SPRITE_ADDR_W = $clog2(SPRITE_NUM * SPRITE_W * SPRITE_H);
  localparam int FB_ADDR_W     = $clog2(FB_W * FB_H);
  localparam int ID_W          = $clog2(SPRITE_NUM);
  localparam int SX_W          = $clog2(SPRITE_W);
  localparam int SY_W          = $clog2(SPRITE_H);
  // Destination coordinates: 16-bit origin plus up to 255*32 pixels of span.
  localparam int POS_W         = 17;
  // Signed row base dy*FB_W over the full reachable dy range.
  localparam int ROW_W         = 26;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD,
    FETCH,
    WRITE
  } blit_state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     x;
    logic [15:0]     y;
    logic [7:0]      scale;
  } blit_entry_t;

  // A replication factor of zero behaves as one.
  function automatic logic [7:0] fix_scale(input logic [7:0] s);
    return (s == 8'd0) ? 8'd1 : s;
  endfunction
endpackage

// File: rtl/sprite_blitter_if.sv
// Draw-queue, sprite-storage and framebuffer signals of the sprite blitter.
interface sprite_blitter_if;
  import sprite_pkg::*;

  logic                     frame_start;
  logic                     is_empty;
  logic [7:0]               sprite_id;
  logic [15:0]              sprite_x;
  logic [15:0]              sprite_y;
  logic [7:0]               sprite_scale;
  logic                     dequeue;
  logic                     sprite_r_en;
  logic [SPRITE_ADDR_W-1:0] sprite_r_addr;
  logic [3:0]               sprite_r_data;
  logic                     fb_w_en;
  logic [FB_ADDR_W-1:0]     fb_w_addr;
  logic [3:0]               fb_w_data;
  logic                     fb_ready;
  logic                     busy;
  logic                     frame_done;
  logic                     overrun;

  modport master (
    input  frame_start, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
           sprite_r_data, fb_ready,
    output dequeue, sprite_r_en, sprite_r_addr, fb_w_en, fb_w_addr, fb_w_data,
           busy, frame_done, overrun
  );

  modport slave (
    output frame_start, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
           sprite_r_data, fb_ready,
    input  dequeue, sprite_r_en, sprite_r_addr, fb_w_en, fb_w_addr, fb_w_data,
           busy, frame_done, overrun
  );
endinterface

// File: rtl/sprite_blit_walker.sv
// Source/destination pixel walker: counters, clip test and address generation.
module sprite_blit_walker
  import sprite_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  blit_entry_t              entry,
  input  logic                     step,
  output logic                     visible,
  output logic                     last,
  output logic [SPRITE_ADDR_W-1:0] sprite_addr,
  output logic [FB_ADDR_W-1:0]     fb_addr
);
  blit_entry_t             cur;
  logic [SX_W-1:0]         sx;
  logic [SY_W-1:0]         sy;
  logic [7:0]              rx;
  logic [7:0]              ry;
  logic signed [POS_W-1:0] dx;
  logic signed [POS_W-1:0] dy;
  logic signed [POS_W-1:0] x_ext;
  logic signed [ROW_W-1:0] y_row;
  logic signed [ROW_W-1:0] row_base;
  logic                    rx_wrap;
  logic                    ry_wrap;
  logic                    sx_wrap;

  assign x_ext   = {cur.x[15], cur.x};
  assign y_row   = {{(ROW_W-16){entry.y[15]}}, entry.y};
  assign rx_wrap = (rx == cur.scale - 8'd1);
  assign ry_wrap = (ry == cur.scale - 8'd1);
  assign sx_wrap = &sx;

  assign visible = (dx >= 0) && (dx < POS_W'(FB_W)) && (dy >= 0) && (dy < POS_W'(FB_H));
  assign last    = sx_wrap && (&sy) && rx_wrap && ry_wrap;

  // Sprite dimensions are powers of two, so the storage address is a plain concatenation.
  assign sprite_addr = {cur.id, sy, sx};
  assign fb_addr     = FB_ADDR_W'(row_base) + FB_ADDR_W'(dx);

  // Latch a new entry on load; otherwise walk one destination pixel per step, row-major.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      sx       <= '0;
      sy       <= '0;
      rx       <= '0;
      ry       <= '0;
      dx       <= '0;
      dy       <= '0;
      row_base <= '0;
    end else if (load) begin
      cur      <= entry;
      sx       <= '0;
      sy       <= '0;
      rx       <= '0;
      ry       <= '0;
      dx       <= {entry.x[15], entry.x};
      dy       <= {entry.y[15], entry.y};
      // y*320 as a constant shift-add, only once per sprite.
      row_base <= (y_row <<< 8) + (y_row <<< 6);
    end else if (step) begin
      if (!rx_wrap) begin
        rx <= rx + 8'd1;
        dx <= dx + 17'sd1;
      end else begin
        rx <= '0;
        if (!sx_wrap) begin
          sx <= sx + SX_W'(1);
          dx <= dx + 17'sd1;
        end else begin
          sx       <= '0;
          dx       <= x_ext;
          dy       <= dy + 17'sd1;
          row_base <= row_base + ROW_W'(FB_W);
          if (!ry_wrap) begin
            ry <= ry + 8'd1;
          end else begin
            ry <= '0;
            sy <= sy + SY_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Frame sequencer: drains the draw queue and blits each sprite into the framebuffer.
// Optional feature macro: SPRITE_BLIT_TRANSPARENCY_EN (colour index 0 is not written).
//
// state | meaning
// IDLE  | waiting for frame_start
// CHECK | test the draw queue; empty ends the frame
// LOAD  | latch the head entry and pop it
// FETCH | clip test; visible pixels issue a storage read
// WRITE | present the pixel to the framebuffer until accepted
module sprite_blitter
  import sprite_pkg::*;
(
  input logic              sys_clock,
  input logic              sys_rst_n,
  sprite_blitter_if.master bus
);
  blit_state_t state;
  blit_state_t state_nxt;
  blit_entry_t entry;
  logic        load;
  logic        step;
  logic        visible;
  logic        last;
  logic        dequeue;
  logic        r_en;
  logic        w_en;
  logic        done;
  logic        unused_id_bits;

  assign entry = '{id:    bus.sprite_id[ID_W-1:0],
                   x:     bus.sprite_x,
                   y:     bus.sprite_y,
                   scale: fix_scale(bus.sprite_scale)};
  assign unused_id_bits = &{1'b0, bus.sprite_id[7:ID_W]};

  sprite_blit_walker u_walker (
    .clk         (sys_clock),
    .rst_n       (sys_rst_n),
    .load        (load),
    .entry       (entry),
    .step        (step),
    .visible     (visible),
    .last        (last),
    .sprite_addr (bus.sprite_r_addr),
    .fb_addr     (bus.fb_w_addr)
  );

  // State register.
  always_ff @(posedge sys_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and control outputs; any completed pixel advances the walker.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    dequeue   = 1'b0;
    r_en      = 1'b0;
    w_en      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (bus.frame_start) state_nxt = CHECK;
      CHECK: begin
        if (bus.is_empty) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        dequeue   = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        if (visible) begin
          r_en      = 1'b1;
          state_nxt = WRITE;
        end else begin
          step = 1'b1;
        end
      end
      WRITE: begin
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
        if (bus.sprite_r_data == 4'd0) begin
          step = 1'b1;
        end else begin
          w_en = 1'b1;
          step = bus.fb_ready;
        end
`else
        w_en = 1'b1;
        step = bus.fb_ready;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (step) state_nxt = last ? CHECK : FETCH;
  end

  assign bus.dequeue     = dequeue;
  assign bus.sprite_r_en = r_en;
  assign bus.fb_w_en     = w_en;
  assign bus.fb_w_data   = (state == WRITE) ? bus.sprite_r_data : 4'd0;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = done;
  assign bus.overrun     = bus.frame_start && (state != IDLE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a pixel-loop reference model.
module tb_sprite_blitter;
  import sprite_pkg::*;

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic sys_clock = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clock = ~sys_clock;

  sprite_blitter_if bus ();
  sprite_blitter dut (.sys_clock(sys_clock), .sys_rst_n(sys_rst_n), .bus(bus));

  typedef struct {int id; int x; int y; int scale;} q_entry_t;
  typedef struct {int addr; int data;} wr_t;

  q_entry_t   draw_q[$];
  wr_t        exp_wr[$];
  int         exp_rd[$];
  logic [3:0] mem [SPRITE_NUM*SPRITE_W*SPRITE_H];

  int checks = 0, passes = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, ovr_cnt = 0, deq_cnt = 0, stall_chk = 0;
  int first_addr = -1, first_data = -1, last_addr = -1;
  bit first_pending = 0, pop_pending = 0, rand_ready = 0, stalled_prev = 0;
  int stall_cycles = 0;
  int prev_addr, prev_data;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic update_head();
    bus.is_empty = (draw_q.size() == 0);
    if (draw_q.size() != 0) begin
      bus.sprite_id    = 8'(draw_q[0].id);
      bus.sprite_x     = 16'(draw_q[0].x);
      bus.sprite_y     = 16'(draw_q[0].y);
      bus.sprite_scale = 8'(draw_q[0].scale);
    end
  endtask

  // Reference model: visit every destination pixel of the scaled sprite in raster order.
  task automatic enqueue(input int id, input int x, input int y, input int scale);
    q_entry_t e;
    int s, sid, dx, dy, a;
    e = '{id, x, y, scale};
    draw_q.push_back(e);
    update_head();
    s   = (scale == 0) ? 1 : scale;
    sid = id % SPRITE_NUM;
    for (int sy = 0; sy < SPRITE_H; sy++)
      for (int ry = 0; ry < s; ry++)
        for (int sx = 0; sx < SPRITE_W; sx++)
          for (int rx = 0; rx < s; rx++) begin
            dx = x + sx * s + rx;
            dy = y + sy * s + ry;
            if (dx >= 0 && dx < FB_W && dy >= 0 && dy < FB_H) begin
              a = sid * SPRITE_W * SPRITE_H + sy * SPRITE_W + sx;
              exp_rd.push_back(a);
              if (!(TRANSP && mem[a] == 4'd0)) exp_wr.push_back('{dy * FB_W + dx, int'(mem[a])});
            end
          end
  endtask

  // Sprite storage: one-cycle read latency, data held between reads.
  always @(posedge sys_clock) if (bus.sprite_r_en) bus.sprite_r_data <= mem[bus.sprite_r_addr];

  // Queue pop takes effect just after the edge that ends the LOAD cycle.
  always @(posedge sys_clock) begin
    if (pop_pending) begin
      pop_pending = 0;
      #1;
      if (draw_q.size() != 0) void'(draw_q.pop_front());
      update_head();
    end
  end

  // Framebuffer ready driver.
  always @(posedge sys_clock) begin
    #1;
    if (stall_cycles > 0) begin
      bus.fb_ready = 1'b0;
      stall_cycles--;
    end else if (rand_ready) begin
      bus.fb_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.fb_ready = 1'b1;
    end
  end

  // Monitor: compare reads and accepted writes against the scoreboard queues.
  always @(negedge sys_clock) begin
    if (sys_rst_n) begin
      if (bus.sprite_r_en) begin
        rd_cnt++;
        check("read_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("read_addr", bus.sprite_r_addr, exp_rd.pop_front());
      end
      if (bus.fb_w_en && bus.fb_ready) begin
        wr_t w;
        wr_cnt++;
        if (first_pending) begin
          first_addr    = bus.fb_w_addr;
          first_data    = bus.fb_w_data;
          first_pending = 0;
        end
        last_addr = bus.fb_w_addr;
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check("write_addr", bus.fb_w_addr, w.addr);
          check("write_data", bus.fb_w_data, w.data);
        end
      end
      if (bus.fb_w_en && !bus.fb_ready) begin
        if (stalled_prev) begin
          stall_chk++;
          check("stall_addr_stable", bus.fb_w_addr, prev_addr);
          check("stall_data_stable", bus.fb_w_data, prev_data);
          check("stall_no_read", bus.sprite_r_en, 0);
        end
        stalled_prev = 1;
        prev_addr    = bus.fb_w_addr;
        prev_data    = bus.fb_w_data;
      end else begin
        stalled_prev = 0;
      end
      if (bus.frame_done) done_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.dequeue) begin
        deq_cnt++;
        pop_pending = 1;
      end
    end
  end

  task automatic pulse_start();
    @(posedge sys_clock); #1 bus.frame_start = 1'b1;
    @(posedge sys_clock); #1 bus.frame_start = 1'b0;
  endtask

  // Start a frame, wait for frame_done and check counts; cycle 1 is the CHECK cycle.
  task automatic run_frame(input string name, input int n_wr, input int n_cyc,
                           input int ovr_at, input int stall_at, input bit timing);
    int wr0, done0, deq0, cyc;
    bit seen;
    wr0 = wr_cnt; done0 = done_cnt; deq0 = deq_cnt;
    cyc = 0; seen = 0;
    first_pending = 1;
    pulse_start();
    while (cyc < 30000 && !seen) begin
      @(negedge sys_clock);
      cyc++;
      if (timing && cyc == 1) begin
        check({name, "_busy_c1"}, bus.busy, 1);
        check({name, "_deq_c1"}, bus.dequeue, 0);
      end
      if (timing && cyc == 2) check({name, "_deq_c2"}, bus.dequeue, 1);
      if (ovr_at != 0 && cyc == ovr_at) begin
        bus.frame_start = 1'b1;
        #1 check({name, "_overrun_hi"}, bus.overrun, 1);
      end
      if (ovr_at != 0 && cyc == ovr_at + 1) begin
        bus.frame_start = 1'b0;
        #1 check({name, "_overrun_lo"}, bus.overrun, 0);
      end
      if (stall_at != 0 && cyc == stall_at) stall_cycles = 5;
      if (bus.frame_done) seen = 1;
    end
    check({name, "_done_seen"}, seen, 1);
    if (n_cyc >= 0) check({name, "_cycles"}, cyc, n_cyc);
    repeat (4) @(negedge sys_clock);
    check({name, "_writes"}, wr_cnt - wr0, n_wr);
    check({name, "_done_once"}, done_cnt - done0, 1);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_busy_after"}, bus.busy, 0);
    if (n_wr == 0) check({name, "_dequeues"}, deq_cnt - deq0, draw_q.size() == 0 ? deq_cnt - deq0 : -1);
  endtask

  initial begin
    int n, st0, rd0;
    bus.frame_start   = 1'b0;
    bus.fb_ready      = 1'b1;
    bus.is_empty      = 1'b1;
    bus.sprite_id     = '0;
    bus.sprite_x      = '0;
    bus.sprite_y      = '0;
    bus.sprite_scale  = '0;
    bus.sprite_r_data = '0;
    for (int i = 0; i < SPRITE_NUM * SPRITE_W * SPRITE_H; i++) mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < SPRITE_W * SPRITE_H; i++) mem[7 * SPRITE_W * SPRITE_H + i] = 4'd0;

    repeat (3) @(negedge sys_clock);
    check("rst_dequeue", bus.dequeue, 0);
    check("rst_r_en", bus.sprite_r_en, 0);
    check("rst_r_addr", bus.sprite_r_addr, 0);
    check("rst_w_en", bus.fb_w_en, 0);
    check("rst_w_addr", bus.fb_w_addr, 0);
    check("rst_w_data", bus.fb_w_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_overrun", bus.overrun, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clock);

    // Empty queue: frame_done in the CHECK cycle, nothing dequeued or written.
    run_frame("empty", 0, 1, 0, 0, 0);
    check("empty_no_deq", deq_cnt, 0);

    // One sprite, scale 1, 2 cycles per visible pixel plus 2 cycles of overhead.
    enqueue(2, 10, 5, 1);
    run_frame("one", 1024, 2051, 0, 0, 1);
    check("one_first_addr", first_addr, 5 * 320 + 10);
    check("one_first_data", first_data, int'(mem[2048]));
    check("one_last_addr", last_addr, 36 * 320 + 41);

    // Scale 2 at the origin, with a frame_start arriving mid-frame.
    enqueue(5, 0, 0, 2);
    run_frame("scale2", 4096, 8195, 300, 0, 0);

    // Clipped against the left and bottom edges.
    rd0 = rd_cnt;
    enqueue(3, -16, 230, 1);
    run_frame("clip", 160, -1, 0, 0, 0);
    check("clip_reads", rd_cnt - rd0, 160);

    // Fully off-screen, scale 2: only FETCH cycles, no reads.
    rd0 = rd_cnt;
    enqueue(1, -200, 50, 2);
    run_frame("offscreen", 0, 4099, 0, 0, 0);
    check("offscreen_reads", rd_cnt - rd0, 0);

    // Framebuffer back-pressure mid-sprite.
    st0 = stall_chk;
    enqueue(4, 50, 60, 0);
    run_frame("stall", 1024, -1, 0, 200, 0);
    check("stall_observed", stall_chk - st0 >= 3, 1);

    // All-zero sprite: written as index 0 unless transparency is enabled.
    enqueue(7, 100, 100, 1);
    run_frame("zero", TRANSP ? 0 : 1024, -1, 0, 0, 0);

    // Randomised multi-sprite frames with random back-pressure.
    rand_ready = 1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 2; k++)
        enqueue($urandom_range(0, 255), int'($urandom_range(0, 380)) - 40,
                int'($urandom_range(0, 300)) - 40, $urandom_range(0, 2));
      n = exp_wr.size();
      run_frame("rand", n, -1, 0, 0, 0);
    end
    rand_ready = 0;

    check("overrun_total", ovr_cnt, 1);
    check("dequeue_total", deq_cnt, 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Frame-level sequencer between the sprite draw queue and the framebuffer. On each frame start it drains the queue one entry at a time, reads each sprite's 4-bit pixels from sprite storage, and writes them scaled and clipped into the framebuffer write port. It is the only reader of sprite storage and the only consumer of the draw queue in the system clock domain.

## Interface
- SPRITE_W, 32: sprite width in pixels, power of two.
- SPRITE_H, 32: sprite height in pixels, power of two.
- SPRITE_NUM, 16: number of stored sprites, power of two.
- FB_W, 320: framebuffer width.
- FB_H, 240: framebuffer height.
- sys_clock  in  1  system clock; all logic on posedge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse that starts drawing a frame.
- is_empty  in  1  draw queue is empty.
- sprite_id  in  8  head entry: sprite index; only the low $clog2(SPRITE_NUM) bits are used.
- sprite_x  in  16  head entry: signed destination x of the top-left corner.
- sprite_y  in  16  head entry: signed destination y of the top-left corner.
- sprite_scale  in  8  head entry: integer replication factor; 0 is treated as 1.
- dequeue  out  1  one-cycle pop of the queue head.
- sprite_r_en  out  1  storage read enable.
- sprite_r_addr  out  SPRITE_ADDR_W  storage read address = id*SPRITE_W*SPRITE_H + sy*SPRITE_W + sx.
- sprite_r_data  in  4  pixel colour index. Valid the cycle after sprite_r_en and held while sprite_r_en is low.
- fb_w_en  out  1  framebuffer write request.
- fb_w_addr  out  $clog2(FB_W*FB_H)  pixel address = dy*FB_W + dx.
- fb_w_data  out  4  pixel colour index.
- fb_ready  in  1  framebuffer accepts the write in the current cycle.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the queue is found empty during a frame.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

## Operation
- States: IDLE, CHECK, LOAD, FETCH, WRITE.
- IDLE:
  - frame_start goes to CHECK.
- CHECK:
  - If is_empty: pulse frame_done and go to IDLE.
  - Otherwise go to LOAD.
- LOAD:
  - Latch id, x, y and scale (0 becomes 1).
  - Pulse dequeue.
  - Clear the counters: source sx/sy, replication rx/ry, destination dx=x, dy=y.
  - Go to FETCH.
- FETCH, for the current (dx, dy):
  - Clipped pixel (dx<0, dx>=FB_W, dy<0 or dy>=FB_H, evaluated signed over 17 bits): no read. Advance and stay in FETCH, or go to CHECK when the sprite is finished.
  - Visible pixel: assert sprite_r_en with the address and go to WRITE.
- WRITE:
  - Drive fb_w_en=1 with fb_w_data=sprite_r_data, and hold all outputs until fb_ready.
  - On acceptance, advance and return to FETCH, or go to CHECK when the sprite is finished.
- Advance order is row-major:
  - rx increments.
  - When rx==scale-1: rx=0 and sx increments.
  - When sx wraps at SPRITE_W: sx=0, ry increments and dx resets to x.
  - When ry==scale-1: ry=0 and sy increments.
  - dx increments with every step; dy increments with every destination row.
- The sprite is finished after the last pixel (sx=SPRITE_W-1, sy=SPRITE_H-1, rx=ry=scale-1).
- fb_w_addr uses an incrementally maintained row base (add FB_W per destination row). No multiplier on the per-pixel path.
- frame_start while busy is ignored and pulses overrun.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- frame_start is sampled at edge N. CHECK is in N+1, LOAD in N+2 (dequeue high in that cycle), first FETCH in N+3.
- Empty queue: frame_done is high in cycle N+1.
- Visible pixel: 2 cycles when fb_ready is held high. Clipped pixel: 1 cycle.
- Per-sprite overhead: 2 cycles (CHECK and LOAD).
- fb_w_en stays high until fb_ready. Address and data are stable during the wait.
- Reset mid-sprite abandons the sprite. The entry already dequeued is lost.
- Sprite fully off-screen: no reads or writes; consumes scale²·SPRITE_W·SPRITE_H FETCH cycles.

## Configuration
- SPRITE_BLIT_TRANSPARENCY_EN defined:
  - A pixel with colour index 0 does not write.
  - WRITE deasserts fb_w_en, ignores fb_ready and advances after 1 cycle.
- Not defined: every visible pixel is written, including index 0.

## Structure
- Shared package sprite_pkg holds:
  - SPRITE_W, SPRITE_H, SPRITE_NUM, FB_W, FB_H.
  - SPRITE_ADDR_W.
  - The blit_state_t enum.
  - A struct for a latched queue entry.
- One sub-module, sprite_blit_walker, holds the sx/sy/rx/ry/dx/dy counters, the clip test and the address generation. It exposes step, visible, last and the addresses.

## Test plan
- Empty queue, frame_start → frame_done in the next cycle; no dequeue, no writes.
- One sprite (id 2, x=10, y=5, scale 1), fb_ready=1:
  - Result: 1024 writes.
  - First write: addr 5*320+10, data from storage addr 2048.
  - Last write: addr 36*320+41.
  - frame_done follows.
- Scale 2 at (0,0): writes (0,0), (1,0), (0,1) and (1,1) all carry source pixel (0,0); 4096 writes total.
- Clipping, x=-16, y=230: only dx 0..15 and dy 230..239 are written; 160 writes with no reads outside them.
- fb_ready held low 5 cycles mid-sprite → fb_w_addr and fb_w_data stable, no extra sprite_r_en.
- Transparency, SPRITE_BLIT_TRANSPARENCY_EN: a sprite of all index 0 produces zero writes. Also frame_start while busy → overrun pulse with the current frame unaffected.
